// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq.
// master drives operands and out_ready; slave (the ALU) drives in_ready, result and flags.
interface alu_seq_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             carry_in;
   logic [3:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] c;
   logic             carry_out;
   logic             zero;
   logic             negative;
   logic             overflow;

   modport master (
      output in_valid, a, b, carry_in, op, out_ready,
      input  in_ready, out_valid, c, carry_out, zero, negative, overflow
   );

   modport slave (
      input  in_valid, a, b, carry_in, op, out_ready,
      output in_ready, out_valid, c, carry_out, zero, negative, overflow
   );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with full flags and a serial shift-add multiplier.
// Latency: result registered on the accept edge; multiply takes WIDTH further cycles.
// Backpressure: one operation in flight; in_ready is low until the held result is taken.
module alu_seq #(
   parameter int WIDTH   = 8,
   parameter int HAS_MUL = 1
) (
   input logic      clk,
   input logic      resetn,
   alu_seq_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   typedef struct packed {
      logic [WIDTH-1:0] val;
      logic             carry;
      logic             zero;
      logic             negative;
      logic             overflow;
   } res_t;

   state_t           state;
   logic             out_valid_q;
   res_t             res_q;
   res_t             alu_res;
   res_t             mul_res;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] mul_hi;
   logic [WIDTH-1:0] mul_lo;
   logic [WIDTH-1:0] mul_b;
   logic [CW-1:0]    mul_cnt;
   logic [WIDTH:0]   mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic             accept;

   assign bus.in_ready  = (state == IDLE);
   assign accept        = bus.in_valid && (state == IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.c         = res_q.val;
   assign bus.carry_out = res_q.carry;
   assign bus.zero      = res_q.zero;
   assign bus.negative  = res_q.negative;
   assign bus.overflow  = res_q.overflow;

   // Every single-cycle op is formed as a WIDTH+1 bit value whose top bit is carry_out.
   always_comb begin
      sum     = '0;
      alu_res = '0;
      case (bus.op)
         4'h0: sum = {1'b0, bus.a} + {1'b0, bus.b};
         4'h1: sum = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.carry_in};
         4'h2: sum = {1'b0, bus.a} - {1'b0, bus.b};
         4'h3: sum = {1'b0, bus.a} - {1'b0, bus.b} - {{WIDTH{1'b0}}, bus.carry_in};
         4'h4: sum = {1'b0, bus.a | bus.b};
         4'h5: sum = {1'b0, bus.a & bus.b};
         4'h6: sum = {1'b0, ~bus.a};
         4'h7: sum = {1'b0, bus.a ^ bus.b};
         4'h8: sum = {bus.a, 1'b0};
         4'h9: sum = {bus.a[0], 1'b0, bus.a[WIDTH-1:1]};
         default: sum = {1'b0, bus.a};
      endcase
      alu_res.val      = sum[WIDTH-1:0];
      alu_res.carry    = sum[WIDTH];
      alu_res.zero     = ~|sum[WIDTH-1:0];
      alu_res.negative = sum[WIDTH-1];
      case (bus.op)
         4'h0, 4'h1: alu_res.overflow = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                                        (sum[WIDTH-1] != bus.a[WIDTH-1]);
         4'h2, 4'h3: alu_res.overflow = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                                        (sum[WIDTH-1] != bus.a[WIDTH-1]);
         default:    alu_res.overflow = 1'b0;
      endcase
   end

   // One multiplier bit per cycle: add B into the high half if the low bit is set, then shift right.
   always_comb begin
      mul_res          = '0;
      mul_sum          = {1'b0, mul_hi} + (mul_lo[0] ? {1'b0, mul_b} : {(WIDTH+1){1'b0}});
      mul_next         = {mul_sum, mul_lo[WIDTH-1:1]};
      mul_res.val      = mul_next[WIDTH-1:0];
      mul_res.carry    = |mul_next[2*WIDTH-1:WIDTH];
      mul_res.zero     = ~|mul_next[WIDTH-1:0];
      mul_res.negative = mul_next[WIDTH-1];
      mul_res.overflow = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state       <= IDLE;
         out_valid_q <= 1'b0;
         res_q       <= '0;
         mul_hi      <= '0;
         mul_lo      <= '0;
         mul_b       <= '0;
         mul_cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (bus.op == 4'hA && HAS_MUL != 0) begin
                     mul_hi  <= '0;
                     mul_lo  <= bus.a;
                     mul_b   <= bus.b;
                     mul_cnt <= CW'(WIDTH);
                     state   <= MUL;
                  end else begin
                     res_q       <= alu_res;
                     out_valid_q <= 1'b1;
                     state       <= DONE;
                  end
               end
            end
            MUL: begin
               mul_hi  <= mul_next[2*WIDTH-1:WIDTH];
               mul_lo  <= mul_next[WIDTH-1:0];
               mul_cnt <= mul_cnt - 1'b1;
               // The last step writes the finished product straight into the result register.
               if (mul_cnt == CW'(1)) begin
                  res_q       <= mul_res;
                  out_valid_q <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// Directed and random operations on alu_seq checked against an arithmetic reference model.
module tb_alu_seq;
   localparam int W = 8;

   logic clk = 1'b0;
   logic resetn;
   int   checks = 0;
   int   errors = 0;

   alu_seq_if #(.WIDTH(W)) bus ();

   alu_seq #(.WIDTH(W), .HAS_MUL(1)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] c;
      logic         carry;
      logic         zero;
      logic         neg;
      logic         ovf;
   } exp_t;

   // Reference: plain integer arithmetic, signed range test for overflow.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic [3:0] op);
      exp_t        e;
      int unsigned ua, ub, uc, r;
      int          sa, sb, ci, sr;
      ua = a; ub = b; uc = cin; ci = cin;
      sa = $signed(a); sb = $signed(b);
      e  = '0;
      r  = ua;
      sr = 0;
      case (op)
         4'h0: begin r = ua + ub;      e.carry = (r >= (1 << W)); sr = sa + sb;      end
         4'h1: begin r = ua + ub + uc; e.carry = (r >= (1 << W)); sr = sa + sb + ci; end
         4'h2: begin r = ua - ub;      e.carry = (ua < ub);       sr = sa - sb;      end
         4'h3: begin r = ua - ub - uc; e.carry = (ua < ub + uc);  sr = sa - sb - ci; end
         4'h4: r = ua | ub;
         4'h5: r = ua & ub;
         4'h6: r = ~ua;
         4'h7: r = ua ^ ub;
         4'h8: begin r = ua * 2; e.carry = (ua >= (1 << (W-1))); end
         4'h9: begin r = ua / 2; e.carry = (ua % 2 == 1);         end
         4'hA: begin r = ua * ub; e.carry = (r >= (1 << W));     end
         default: r = ua;
      endcase
      if (op <= 4'h3)
         e.ovf = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
      e.c    = r[W-1:0];
      e.zero = (e.c == '0);
      e.neg  = (int'(e.c) >= (1 << (W-1)));
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic chk_res(input string pfx, input exp_t e);
      chk({pfx, "_c"},     32'(bus.c),         32'(e.c));
      chk({pfx, "_carry"}, 32'(bus.carry_out), 32'(e.carry));
      chk({pfx, "_zero"},  32'(bus.zero),      32'(e.zero));
      chk({pfx, "_neg"},   32'(bus.negative),  32'(e.neg));
      chk({pfx, "_ovf"},   32'(bus.overflow),  32'(e.ovf));
   endtask

   // Called at #1 after a rising edge with the ALU idle; returns at #1 after the drain edge.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic [3:0] op, input int hold);
      exp_t e;
      int   lat;
      e = model(a, b, cin, op);
      chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1; bus.a = a; bus.b = b; bus.carry_in = cin; bus.op = op;
      @(posedge clk); #1;
      // Scramble operands after the accept edge: the ALU must have latched them.
      bus.in_valid = 1'b0;
      bus.a = W'($urandom); bus.b = W'($urandom);
      bus.carry_in = 1'($urandom); bus.op = 4'($urandom);
      lat = 0;
      while (bus.out_valid !== 1'b1 && lat < 4 * W) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("edges_to_valid", 32'(lat), (op == 4'hA) ? 32'(W) : 32'd0);
      chk_res("res", e);
      for (int i = 0; i < hold; i++) begin
         bus.in_valid = 1'b1;
         @(posedge clk); #1;
         chk_res("hold", e);
         chk("hold_in_ready",  32'(bus.in_ready),  32'd0);
         chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk("drain_out_valid", 32'(bus.out_valid), 32'd0);
      chk("drain_in_ready",  32'(bus.in_ready),  32'd1);
   endtask

   initial begin
      logic stale;
      resetn        = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.carry_in  = 1'b0;
      bus.op        = 4'h0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
      chk_res("rst", exp_t'('0));
      resetn = 1'b1;
      @(posedge clk); #1;

      run_op(8'hFF, 8'h01, 1'b0, 4'h0, 0);
      run_op(8'h00, 8'h00, 1'b1, 4'h3, 0);
      run_op(8'h80, 8'h01, 1'b0, 4'h2, 0);
      run_op(8'h7F, 8'h00, 1'b1, 4'h1, 0);
      run_op(8'h81, 8'h00, 1'b0, 4'h8, 0);
      run_op(8'h01, 8'h00, 1'b0, 4'h9, 0);
      run_op(8'h10, 8'h10, 1'b0, 4'hA, 0);
      run_op(8'hFF, 8'hFF, 1'b0, 4'hA, 5);
      run_op(8'h5A, 8'h33, 1'b1, 4'h0, 5);

      for (int n = 0; n < 80; n++)
         run_op(W'($urandom), W'($urandom), 1'($urandom), 4'($urandom), $urandom_range(0, 3));

      // Reset lands on the 4th multiply cycle.
      bus.in_valid = 1'b1; bus.a = 8'h10; bus.b = 8'h10; bus.op = 4'hA;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      resetn = 1'b0;
      @(posedge clk); #1;
      chk("midmul_out_valid", 32'(bus.out_valid), 32'd0);
      chk("midmul_in_ready",  32'(bus.in_ready),  32'd1);
      chk_res("midmul", exp_t'('0));
      resetn = 1'b1;
      stale  = 1'b0;
      repeat (2 * W) begin
         @(posedge clk); #1;
         if (bus.out_valid !== 1'b0) stale = 1'b1;
      end
      chk("no_stale_result", 32'(stale), 32'd0);
      run_op(8'h22, 8'h11, 1'b0, 4'h2, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
